// File: rtl/width_pack_n.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one word with
// valid/ready on both sides, selectable lane order and last-driven partial flush.
module width_pack_n #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  last_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [IN_W*RATIO-1:0] data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic                  last_out
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic             valid_out_q, valid_out_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [RATIO-1:0] keep_out_q, keep_out_d;
  logic             last_out_q, last_out_d;

  logic             beat_fire;
  logic             word_fire;
  logic             word_done;
  logic [CNT_W-1:0] lane;
  logic [OUT_W-1:0] beat_vec;
  logic [RATIO-1:0] beat_keep;

  // A pending word blocks new beats unless it is being consumed this edge.
  assign ready_in  = !valid_out_q || ready_out;
  assign beat_fire = valid_in && ready_in;
  assign word_fire = valid_out_q && ready_out;
  assign word_done = (cnt_q == CNT_MAX) || last_in;
  assign lane      = LSB_FIRST ? cnt_q : (CNT_MAX - cnt_q);

  // Unwritten lanes stay zero, so placing a beat is a plain OR into the word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    beat_vec  = '0;
    beat_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CNT_W'(i)) begin
        beat_vec[i*IN_W +: IN_W] = data_in;
        beat_keep[i]             = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_keep_d  = acc_keep_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;

    // Consume first; a completing beat on the same edge re-raises valid.
    if (word_fire) begin
      valid_out_d = 1'b0;
    end

    if (beat_fire) begin
      if (word_done) begin
        data_out_d  = acc_q | beat_vec;
        keep_out_d  = acc_keep_q | beat_keep;
        last_out_d  = last_in;
        valid_out_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
        acc_keep_d  = '0;
      end else begin
        acc_d       = acc_q | beat_vec;
        acc_keep_d  = acc_keep_q | beat_keep;
        cnt_d       = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the accumulator is reset too, because a reset must discard a
    // half-built word and the OR-merge relies on unwritten lanes being zero.
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_keep_q  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_keep_q  <= acc_keep_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_width_pack_n.sv
// Bench for width_pack_n: three configurations share one stimulus stream and are
// each compared every cycle with a beat-list reference model plus directed checks.
module tb_width_pack_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       last_in;
  logic       ready_out;
  logic [7:0] data_in;

  logic        rdy_m, vo_m, lo_m;
  logic [31:0] do_m;
  logic [3:0]  ko_m;
  logic        rdy_l, vo_l, lo_l;
  logic [31:0] do_l;
  logic [3:0]  ko_l;
  logic        rdy_2, vo_2, lo_2;
  logic [15:0] do_2;
  logic [1:0]  ko_2;

  always #5 clk = ~clk;

  width_pack_n #(.IN_W(8), .RATIO(4), .LSB_FIRST(1'b0)) u_r4_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_m), .data_in(data_in),
    .last_in(last_in), .valid_out(vo_m), .ready_out(ready_out), .data_out(do_m),
    .keep_out(ko_m), .last_out(lo_m));

  width_pack_n #(.IN_W(8), .RATIO(4), .LSB_FIRST(1'b1)) u_r4_lsb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_l), .data_in(data_in),
    .last_in(last_in), .valid_out(vo_l), .ready_out(ready_out), .data_out(do_l),
    .keep_out(ko_l), .last_out(lo_l));

  width_pack_n #(.IN_W(8), .RATIO(2), .LSB_FIRST(1'b0)) u_r2_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_2), .data_in(data_in),
    .last_in(last_in), .valid_out(vo_2), .ready_out(ready_out), .data_out(do_2),
    .keep_out(ko_2), .last_out(lo_2));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per configuration, the list of beats of the current word;
  // the word is assembled by lane arithmetic only when it completes.
  int          ratio_m[3] = '{4, 4, 2};
  bit          lsb_m[3]   = '{1'b0, 1'b1, 1'b0};
  string       name_m[3]  = '{"r4_msb", "r4_lsb", "r2_msb"};
  logic [7:0]  pend[3][4];
  int          pcnt[3];
  logic        m_v[3];
  logic [31:0] m_d[3];
  logic [3:0]  m_k[3];
  logic        m_l[3];
  int          accepted[3];
  int          consumed[3];
  bit          check_en = 1'b0;
  bit          count_en = 1'b0;

  task automatic model_step();
    for (int j = 0; j < 3; j++) begin
      logic        rdy;
      logic [31:0] w;
      logic [3:0]  k;
      int          ln;
      rdy = !m_v[j] || ready_out;
      if (rst) begin
        m_v[j] = 1'b0; m_d[j] = '0; m_k[j] = '0; m_l[j] = 1'b0; pcnt[j] = 0;
      end else begin
        if (m_v[j] && ready_out) m_v[j] = 1'b0;
        if (valid_in && rdy) begin
          pend[j][pcnt[j]] = data_in;
          pcnt[j]++;
          if (count_en) accepted[j]++;
          if (pcnt[j] == ratio_m[j] || last_in) begin
            w = '0;
            k = '0;
            for (int b = 0; b < pcnt[j]; b++) begin
              ln = lsb_m[j] ? b : ratio_m[j] - 1 - b;
              w = w | (32'(pend[j][b]) << (8 * ln));
              k[ln] = 1'b1;
            end
            m_d[j] = w; m_k[j] = k; m_l[j] = last_in; m_v[j] = 1'b1;
            pcnt[j] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < 3; j++) begin
      logic        g_v, g_r, g_l;
      logic [31:0] g_d;
      logic [3:0]  g_k;
      case (j)
        0:       begin g_v = vo_m; g_r = rdy_m; g_l = lo_m; g_d = do_m;      g_k = ko_m; end
        1:       begin g_v = vo_l; g_r = rdy_l; g_l = lo_l; g_d = do_l;      g_k = ko_l; end
        default: begin g_v = vo_2; g_r = rdy_2; g_l = lo_2; g_d = 32'(do_2); g_k = 4'(ko_2); end
      endcase
      check({name_m[j], ".valid_out"}, 32'(g_v), 32'(m_v[j]));
      check({name_m[j], ".ready_in"},  32'(g_r), 32'(!m_v[j] || ready_out));
      check({name_m[j], ".data_out"},  g_d, m_d[j]);
      check({name_m[j], ".keep_out"},  32'(g_k), 32'(m_k[j]));
      check({name_m[j], ".last_out"},  32'(g_l), 32'(m_l[j]));
      if (count_en && g_v === 1'b1 && ready_out) consumed[j] += $countones(g_k);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (check_en) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    valid_in = 1'b1; data_in = d; last_in = l;
    cycle();
  endtask

  task automatic idle();
    valid_in = 1'b0; last_in = 1'b0; data_in = 8'h00;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; ready_out = 1'b1; data_in = 8'h00;
    for (int j = 0; j < 3; j++) begin
      pcnt[j] = 0; m_v[j] = 1'b0; m_d[j] = '0; m_k[j] = '0; m_l[j] = 1'b0;
      accepted[j] = 0; consumed[j] = 0;
    end
    @(posedge clk); #1;
    cycle();
    check_en = 1'b1;
    cycle();
    check("reset.valid", 32'({vo_m, vo_l, vo_2}), 32'd0);
    check("reset.data",  do_m | do_l | 32'(do_2), 32'd0);
    check("reset.keep",  32'({ko_m, ko_l, ko_2}), 32'd0);
    check("reset.last",  32'({lo_m, lo_l, lo_2}), 32'd0);
    rst = 1'b0;

    // Full words in both lane orders.
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    check("t1.msb.data", do_m, 32'h1122_3344);
    check("t1.msb.keep", 32'(ko_m), 32'hF);
    check("t1.msb.last", 32'(lo_m), 32'd0);
    check("t1.msb.valid", 32'(vo_m), 32'd1);
    check("t2.lsb.data", do_l, 32'h4433_2211);
    check("t2.lsb.keep", 32'(ko_l), 32'hF);
    check("t1.r2.data", 32'(do_2), 32'h3344);
    idle();
    check("t1.msb.valid_drop", 32'(vo_m), 32'd0);
    check("t1.msb.data_hold", do_m, 32'h1122_3344);

    // Partial flush on last, then a fresh word starting in the top lane.
    beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
    check("t3.msb.data", do_m, 32'hAABB_0000);
    check("t3.msb.keep", 32'(ko_m), 32'hC);
    check("t3.msb.last", 32'(lo_m), 32'd1);
    check("t3.lsb.data", do_l, 32'h0000_BBAA);
    check("t3.lsb.keep", 32'(ko_l), 32'h3);
    beat(8'hCC, 1'b0); beat(8'hDD, 1'b0); beat(8'hEE, 1'b0); beat(8'hFF, 1'b0);
    check("t3.msb.fresh", do_m, 32'hCCDD_EEFF);
    check("t3.msb.fresh_keep", 32'(ko_m), 32'hF);

    // Single-beat packet.
    beat(8'h5A, 1'b1);
    check("t6.lsb.data", do_l, 32'h0000_005A);
    check("t6.lsb.keep", 32'(ko_l), 32'h1);
    check("t6.lsb.last", 32'(lo_l), 32'd1);
    check("t6.msb.data", do_m, 32'h5A00_0000);
    check("t6.msb.keep", 32'(ko_m), 32'h8);
    check("t6.r2.keep", 32'(ko_2), 32'h2);
    idle();

    // Backpressure on the RATIO=2 instance.
    ready_out = 1'b0;
    beat(8'h12, 1'b0); beat(8'h34, 1'b0);
    idle(); idle();
    check("t4.r2.ready_stall", 32'(rdy_2), 32'd0);
    check("t4.r2.data_hold", 32'(do_2), 32'h1234);
    check("t4.r2.valid_hold", 32'(vo_2), 32'd1);
    ready_out = 1'b1;
    beat(8'h56, 1'b0);
    check("t4.r2.consumed", 32'(vo_2), 32'd0);
    beat(8'h78, 1'b0);
    check("t4.r2.next", 32'(do_2), 32'h5678);
    check("t4.msb.word", do_m, 32'h1234_5678);
    idle();

    // Reset in the middle of a word.
    beat(8'hA1, 1'b0); beat(8'hA2, 1'b0);
    rst = 1'b1;
    idle();
    check("t5.rst.data", do_m | do_l | 32'(do_2), 32'd0);
    check("t5.rst.valid", 32'({vo_m, vo_l, vo_2}), 32'd0);
    rst = 1'b0;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    check("t5.msb.data", do_m, 32'h0102_0304);
    check("t5.lsb.data", do_l, 32'h0403_0201);
    check("t5.msb.keep", 32'(ko_m), 32'hF);
    idle();

    // Random traffic with random stalls; beats must be conserved end to end.
    count_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      data_in   = 8'($urandom);
      last_in   = ($urandom_range(0, 7) == 0);
      ready_out = ($urandom_range(0, 2) != 0);
      cycle();
    end
    ready_out = 1'b1;
    beat(8'($urandom), 1'b1);
    idle(); idle(); idle();
    for (int j = 0; j < 3; j++)
      check({name_m[j], ".beat_count"}, 32'(consumed[j]), 32'(accepted[j]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/width_pack_n.md
Name: width_pack_n

Overview:
- Parametrised narrow-to-wide data packer, successor to the fixed 8-to-16 converter.
- Gathers RATIO input beats of IN_W bits into one OUT_W = IN_W*RATIO word.
- Adds valid/ready backpressure, a selectable lane order, and flush of partial words on last_in with a lane-keep mask.
- Sits between byte-oriented producers and wide datapath consumers.

Parameters:
- IN_W, 8, input beat width in bits (>=1).
- RATIO, 2, input beats per output word (>=2); OUT_W = IN_W*RATIO.
- LSB_FIRST, 0, lane order. 0: first beat lands in the most significant lane. 1: first beat lands in the least significant lane.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- valid_in  input  1  input beat valid.
- ready_in  output  1  packer can accept a beat.
- data_in  input  IN_W  input beat.
- last_in  input  1  final beat of a packet; forces emission of the current word.
- valid_out  output  1  output word valid.
- ready_out  input  1  downstream accepts word.
- data_out  output  OUT_W  packed word.
- keep_out  output  RATIO  one bit per lane; 1 = lane holds real data. Bit i maps to the lane at data_out[i*IN_W +: IN_W].
- last_out  output  1  word ends a packet.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset state: valid_out=0, data_out=0, keep_out=0, last_out=0, beat counter cnt=0, accumulator=0.
- Reset also clears any partial word and any pending output word, even mid-packet.
- Input handshake: a beat is accepted on an edge where valid_in && ready_in.
- Output handshake: a word is consumed on an edge where valid_out && ready_out.
- ready_in = !valid_out || ready_out. This is combinational from ready_out and does not depend on valid_in or last_in.
- cnt counts accepted beats in the current word, 0..RATIO-1; its width is clog2(RATIO).
- Lane placement, beat k of a word (k=0 first):
  - LSB_FIRST=0: lane RATIO-1-k.
  - LSB_FIRST=1: lane k.
- Accepted beat with cnt<RATIO-1 and last_in=0: store it in its lane of the accumulator; cnt increments; no output change.
- Completing beat (cnt==RATIO-1 or last_in=1), on the edge it is accepted:
  - data_out = accumulator merged with this beat; lanes not yet written are 0.
  - keep_out has exactly the written lanes set.
  - last_out = last_in; valid_out=1.
  - cnt and accumulator clear to 0.
- Latency: the word is visible in the cycle after the completing beat's edge, i.e. 1-cycle latency from the completing beat.
- A full word with last_in=1 gives keep_out all ones and last_out=1.
- Single-beat packet (cnt==0, last_in=1) gives one word with one lane kept.
- Output hold: while valid_out && !ready_out, data_out, keep_out and last_out are stable.
- Consume without a new completing beat: valid_out goes to 0, and data_out/keep_out/last_out hold their values.
- Consume plus completing beat on the same edge: the new word loads and valid_out stays 1. Back-to-back full throughput is one word every RATIO cycles.
- Partial-beat acceptance: while the output is stalled, ready_in=0, so no beats are accepted.
- Accumulator contents persist across idle cycles (valid_in=0). No timeout flush.
- data_in is ignored when valid_in=0 or ready_in=0.
- RATIO=2, LSB_FIRST=0, with ready_out tied high, gives the same packed word as the legacy 8-to-16 block, {first, second}, plus keep_out=2'b11.

Test Plan:
1. IN_W=8, RATIO=4, LSB_FIRST=0, ready_out=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44: data_out=0x11223344, keep_out=4'b1111, last_out=0, valid_out high for 1 cycle.
2. Same config, LSB_FIRST=1, same beats -> data_out=0x44332211, keep_out=4'b1111.
3. RATIO=4, beats 0xAA,0xBB with last_in on 0xBB -> data_out=0xAABB0000, keep_out=4'b1100, last_out=1. The next beat 0xCC starts a fresh word in lane 3.
4. Backpressure, RATIO=2: word 0x1234 pending with ready_out=0 -> ready_in=0 and data_out held at 0x1234. Raise ready_out while beats 0x56,0x78 are offered -> 0x1234 consumed, then 0x5678 presented. No beat lost or duplicated over 100 random stalls (scoreboard).
5. Reset mid-word, RATIO=4: 2 beats accepted, assert rst 1 cycle, then 4 beats 0x01..0x04 -> output 0x01020304 only, no trace of the earlier beats. All outputs 0 during reset.
6. Single-beat packet: cnt=0, 0x5A with last_in, RATIO=4, LSB_FIRST=1 -> data_out=0x0000005A, keep_out=4'b0001, last_out=1.
